input_unload: RTL and testbench

//   Reader for the 128-bit keypad input buffer. The buffer shifts digits in from the LSB end and

---
 rtl/doorlock_pkg.sv | 16 +
 rtl/input_unload.sv | 110 +++++++++++
 tb/tb_input_unload.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/doorlock_pkg.sv
// Shared constants and FSM encoding for the keypad/door-lock datapath.
package doorlock_pkg;

  localparam int           NIBBLES = 32;
  localparam logic [3:0]   PAD     = 4'hF;
  localparam int           BUF_W   = 4 * NIBBLES;
  localparam logic [5:0]   NIB_CNT = 6'(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } unload_state_t;

endpackage

// File: rtl/input_unload.sv
// Unloads the keypad input buffer: strips leading pad nibbles, then streams
// the entered digits oldest-first over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SCAN  | skipping leading pad nibbles, one per cycle
// SEND  | presenting snap[top] as a digit until the last one is accepted
// DONE  | one-cycle done pulse, then back to IDLE
module input_unload
  import doorlock_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [BUF_W-1:0] data_in,
  output logic [3:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic [5:0]       len,
  output logic             busy,
  output logic             done
);

  unload_state_t    state;
  logic [BUF_W-1:0] snap;
  logic [BUF_W-1:0] snap_shift;
  logic [5:0]       cnt;
  logic [5:0]       rem;
  logic [5:0]       digits;
  logic             top_is_pad;
  logic             handshake;

  assign dout       = snap[BUF_W-1 -: 4];
  assign snap_shift = {snap[BUF_W-5:0], PAD};
  assign top_is_pad = (snap[BUF_W-1 -: 4] == PAD);
  assign digits     = NIB_CNT - cnt;
  assign handshake  = dout_valid & dout_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      snap       <= {NIBBLES{PAD}};
      cnt        <= 6'd0;
      rem        <= 6'd0;
      len        <= 6'd0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // len is deliberately kept so the caller can still read the last count
        state      <= IDLE;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              snap  <= data_in;
              cnt   <= 6'd0;
              busy  <= 1'b1;
              state <= SCAN;
            end
          end
          SCAN: begin
            if (!top_is_pad) begin
              len        <= digits;
              rem        <= digits;
              dout_valid <= 1'b1;
              dout_last  <= (digits == 6'd1);
              state      <= SEND;
            end else begin
              snap <= snap_shift;
              cnt  <= cnt + 6'd1;
              if (cnt == NIB_CNT - 6'd1) begin
                len   <= 6'd0;
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          SEND: begin
            if (handshake) begin
              snap <= snap_shift;
              rem  <= rem - 6'd1;
              if (rem == 6'd1) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end else begin
                dout_last <= (rem == 6'd2);
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_unload.sv
// Directed bench for input_unload: hand-computed digit streams, latencies and control cases.
module tb_input_unload;
  import doorlock_pkg::*;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             abort;
  logic [BUF_W-1:0] data_in;
  logic [3:0]       dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic [5:0]       len;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [BUF_W-1:0] BUF_1234  = {{28{4'hF}}, 16'h1234};
  localparam logic [BUF_W-1:0] BUF_PAD   = {32{4'hF}};
  localparam logic [BUF_W-1:0] BUF_FULL  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [BUF_W-1:0] BUF_5F7   = {{29{4'hF}}, 12'h5F7};

  input_unload dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .data_in(data_in),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .len(len), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [BUF_W-1:0] d);
    data_in = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n, output bit saw_done);
    n = 0;
    saw_done = 1'b0;
    while (!dout_valid && n < max) begin
      step();
      n++;
      if (done) saw_done = 1'b1;
    end
  endtask

  task automatic stream_ready(input string tag, input logic [3:0] d[], input int cnt);
    for (int j = 0; j < cnt; j++) begin
      chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
      chk({tag, "_dout"}, 32'(dout), 32'(d[j]));
      chk({tag, "_last"}, 32'(dout_last), 32'(j == cnt - 1));
      step();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_valid_off"}, 32'(dout_valid), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit saw_done;
    int valid_seen;
    logic [3:0] d1234[] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [3:0] d5f7[]  = '{4'h5, 4'hF, 4'h7};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b0; data_in = '0;
    #22;
    chk("rst_dout", 32'(dout), 32'hF);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    step();

    // four digits at the bottom, ready held high
    dout_ready = 1'b1;
    do_start(BUF_1234);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_valid(100, n, saw_done);
    chk("t1_latency", 32'(n), 32'd29);
    chk("t1_len", 32'(len), 32'd4);
    stream_ready("t1", d1234, 4);

    // all pad: done after 32 cycles, never valid
    do_start(BUF_PAD);
    n = 0;
    valid_seen = 0;
    while (!done && n < 100) begin
      step();
      n++;
      if (dout_valid) valid_seen++;
    end
    chk("t2_done_cyc", 32'(n), 32'd32);
    chk("t2_no_valid", 32'(valid_seen), 32'd0);
    chk("t2_len", 32'(len), 32'd0);
    step();
    chk("t2_busy", 32'(busy), 32'd0);

    // full buffer, ready toggling
    dout_ready = 1'b0;
    do_start(BUF_FULL);
    wait_valid(100, n, saw_done);
    chk("t3_latency", 32'(n), 32'd1);
    chk("t3_len", 32'(len), 32'd32);
    for (int j = 0; j < 32; j++) begin
      chk("t3_dout", 32'(dout), 32'(j % 16));
      step();
      chk("t3_hold_valid", 32'(dout_valid), 32'd1);
      chk("t3_hold_dout", 32'(dout), 32'(j % 16));
      chk("t3_hold_last", 32'(dout_last), 32'(j == 31));
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
    end
    chk("t3_done", 32'(done), 32'd1);
    step();

    // interior pad emitted as data
    dout_ready = 1'b1;
    do_start(BUF_5F7);
    wait_valid(100, n, saw_done);
    chk("t4_latency", 32'(n), 32'd30);
    chk("t4_len", 32'(len), 32'd3);
    stream_ready("t4", d5f7, 3);

    // abort on the second SEND cycle
    do_start(BUF_1234);
    wait_valid(100, n, saw_done);
    chk("t5_latency", 32'(n), 32'd29);
    step();
    chk("t5_second_dout", 32'(dout), 32'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_valid", 32'(dout_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_len", 32'(len), 32'd4);
    step();
    chk("t5_done_late", 32'(done), 32'd0);

    // restart cleanly; start re-pulsed while busy and data_in changed are ignored
    do_start(BUF_5F7);
    data_in = BUF_FULL;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(100, n, saw_done);
    chk("t6_latency", 32'(n), 32'd28);
    chk("t6_len", 32'(len), 32'd3);
    stream_ready("t6", d5f7, 3);

    // start together with abort stays idle
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t7_busy", 32'(busy), 32'd0);
    step();
    chk("t7_busy2", 32'(busy), 32'd0);

    // async reset mid-SEND
    dout_ready = 1'b0;
    do_start(BUF_1234);
    wait_valid(100, n, saw_done);
    chk("t8_valid_pre", 32'(dout_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t8_valid", 32'(dout_valid), 32'd0);
    chk("t8_dout", 32'(dout), 32'hF);
    chk("t8_last", 32'(dout_last), 32'd0);
    chk("t8_len", 32'(len), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    step();
    rstn = 1'b1;
    step();
    chk("t8_done", 32'(done), 32'd0);
    chk("t8_busy_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
